// File: rtl/noc_net_iface.sv
// noc_net_iface: network interface between a processing core and the local
// port of a mesh router.
//   TX: core requests are packetised into 64-bit flits {data, src, dest} and
//       queued toward the router's local input.
//   RX: flits from the router's local output are checked against node_addr
//       and queued for the core. Mismatches and overflows are dropped and
//       recorded in sticky flags.
// Both directions use independent circular FIFOs with DEPTH entries.
// Optional build macro NI_STATS_EN adds saturating injection, ejection and
// drop counters.
module noc_net_iface #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  node_addr,
  input  logic        core_tx_valid,
  output logic        core_tx_ready,
  input  logic [3:0]  core_tx_dest,
  input  logic [55:0] core_tx_data,
  output logic [63:0] flit_out,
  output logic        flit_out_valid,
  input  logic        flit_out_ready,
  input  logic [63:0] flit_in,
  input  logic        flit_in_valid,
  output logic        core_rx_valid,
  input  logic        core_rx_ready,
  output logic [3:0]  core_rx_src,
  output logic [55:0] core_rx_data,
  input  logic        err_clr,
  output logic        rx_overflow,
  output logic        misroute
`ifdef NI_STATS_EN
  ,
  output logic [15:0] inj_count,
  output logic [15:0] ej_count,
  output logic [15:0] drop_count
`endif
);

  // One extra pointer bit separates full from empty when the low bits match.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  // Saturating 16-bit increment for the statistics counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------------------------------------------------------- TX FIFO
  logic [63:0]   tx_mem [DEPTH];
  logic [PW-1:0] tx_wr_ptr;
  logic [PW-1:0] tx_rd_ptr;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push;
  logic          tx_pop;
  logic [63:0]   tx_flit;

  assign tx_full  = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) &&
                    (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);

  assign core_tx_ready  = !tx_full;
  assign flit_out_valid = !tx_empty;
  // Gate the head with empty so the output reads 0 whenever nothing is queued,
  // including immediately on reset, without resetting the storage array.
  assign flit_out       = tx_empty ? 64'd0 : tx_mem[tx_rd_ptr[AW-1:0]];

  assign tx_push = core_tx_valid & !tx_full;
  assign tx_pop  = !tx_empty & flit_out_ready;
  // Source field is this node; destination comes from the core.
  assign tx_flit = {core_tx_data, node_addr, core_tx_dest};

  // TX storage write; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[AW-1:0]] <= tx_flit;
  end

  // TX pointer update; pointers wrap modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [63:0]   rx_mem [DEPTH];
  logic [PW-1:0] rx_wr_ptr;
  logic [PW-1:0] rx_rd_ptr;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_pop;
  logic          rx_dest_ok;
  logic          rx_slot_free;
  logic          rx_push;
  logic          rx_misroute_evt;
  logic          rx_overflow_evt;
  logic [63:0]   rx_head;

  assign rx_full  = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) &&
                    (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);

  assign core_rx_valid = !rx_empty;
  assign rx_head       = rx_empty ? 64'd0 : rx_mem[rx_rd_ptr[AW-1:0]];
  assign core_rx_src   = rx_head[7:4];
  assign core_rx_data  = rx_head[63:8];

  assign rx_pop = !rx_empty & core_rx_ready;

  // Everything derived from flit_in is qualified by flit_in_valid first so
  // that X content on an idle bus cannot reach state.
  assign rx_dest_ok      = flit_in_valid && (flit_in[3:0] == node_addr);
  // A pop in the same cycle frees the slot the incoming flit needs.
  assign rx_slot_free    = !rx_full || rx_pop;
  assign rx_push         = rx_dest_ok && rx_slot_free;
  assign rx_misroute_evt = flit_in_valid && !rx_dest_ok;
  assign rx_overflow_evt = rx_dest_ok && !rx_slot_free;

  // RX storage write; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[AW-1:0]] <= flit_in;
  end

  // RX pointer update; pointers wrap modulo 2*DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
    end
  end

  // ---------------------------------------------------------- error flags
  // Sticky flags; a new error in the same cycle as err_clr wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misroute    <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_misroute_evt)  misroute <= 1'b1;
      else if (err_clr)     misroute <= 1'b0;
      if (rx_overflow_evt)  rx_overflow <= 1'b1;
      else if (err_clr)     rx_overflow <= 1'b0;
    end
  end

`ifdef NI_STATS_EN
  // ---------------------------------------------------------- statistics
  // Saturating counters; cleared only by reset, never by err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_count  <= 16'd0;
      ej_count   <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      if (tx_pop)                             inj_count  <= sat_inc(inj_count);
      if (rx_push)                            ej_count   <= sat_inc(ej_count);
      if (rx_misroute_evt || rx_overflow_evt) drop_count <= sat_inc(drop_count);
    end
  end
`endif

endmodule

// File: tb/tb_noc_net_iface.sv
// Directed bench for noc_net_iface (DEPTH=4). Inputs change 1 time unit
// after a rising edge; outputs are checked in the same quiet window.
module tb_noc_net_iface;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  node_addr;
  logic        core_tx_valid;
  logic        core_tx_ready;
  logic [3:0]  core_tx_dest;
  logic [55:0] core_tx_data;
  logic [63:0] flit_out;
  logic        flit_out_valid;
  logic        flit_out_ready;
  logic [63:0] flit_in;
  logic        flit_in_valid;
  logic        core_rx_valid;
  logic        core_rx_ready;
  logic [3:0]  core_rx_src;
  logic [55:0] core_rx_data;
  logic        err_clr;
  logic        rx_overflow;
  logic        misroute;
`ifdef NI_STATS_EN
  logic [15:0] inj_count;
  logic [15:0] ej_count;
  logic [15:0] drop_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  noc_net_iface #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .node_addr(node_addr),
    .core_tx_valid(core_tx_valid), .core_tx_ready(core_tx_ready),
    .core_tx_dest(core_tx_dest), .core_tx_data(core_tx_data),
    .flit_out(flit_out), .flit_out_valid(flit_out_valid),
    .flit_out_ready(flit_out_ready),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid),
    .core_rx_valid(core_rx_valid), .core_rx_ready(core_rx_ready),
    .core_rx_src(core_rx_src), .core_rx_data(core_rx_data),
    .err_clr(err_clr), .rx_overflow(rx_overflow), .misroute(misroute)
`ifdef NI_STATS_EN
    ,
    .inj_count(inj_count), .ej_count(ej_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_fov"}, {63'd0, flit_out_valid}, 64'd0);
    chk({tag, "_fo"}, flit_out, 64'd0);
    chk({tag, "_rxv"}, {63'd0, core_rx_valid}, 64'd0);
    chk({tag, "_rxsrc"}, {60'd0, core_rx_src}, 64'd0);
    chk({tag, "_rxdata"}, {8'd0, core_rx_data}, 64'd0);
    chk({tag, "_ovf"}, {63'd0, rx_overflow}, 64'd0);
    chk({tag, "_mis"}, {63'd0, misroute}, 64'd0);
`ifdef NI_STATS_EN
    chk({tag, "_inj"}, {48'd0, inj_count}, 64'd0);
    chk({tag, "_ej"}, {48'd0, ej_count}, 64'd0);
    chk({tag, "_drop"}, {48'd0, drop_count}, 64'd0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    node_addr = 4'h5;
    core_tx_valid = 1'b0; core_tx_dest = 4'h0; core_tx_data = 56'd0;
    flit_out_ready = 1'b0;
    flit_in = 64'hx; flit_in_valid = 1'b0;
    core_rx_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk_all_zero("rst");
    chk("rst_txrdy", {63'd0, core_tx_ready}, 64'd1);
    rst = 1'b0;
    tick();

    // ---- single TX flit, one cycle latency, visible for exactly one cycle
    core_tx_valid = 1'b1; core_tx_dest = 4'h9; core_tx_data = 56'h1;
    flit_out_ready = 1'b1;
    chk("t1_nofall", {63'd0, flit_out_valid}, 64'd0);
    tick();
    core_tx_valid = 1'b0;
    chk("t1_fov", {63'd0, flit_out_valid}, 64'd1);
    chk("t1_fo", flit_out, 64'h0000_0000_0000_0159);
    tick();
    chk("t1_gone", {63'd0, flit_out_valid}, 64'd0);

    // ---- TX fill with backpressure, then drain in order
    flit_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      core_tx_valid = 1'b1; core_tx_dest = k[3:0]; core_tx_data = 56'h100 + 56'(k);
      chk("t2_rdy_fill", {63'd0, core_tx_ready}, 64'd1);
      tick();
    end
    core_tx_dest = 4'h4; core_tx_data = 56'h104;
    chk("t2_full", {63'd0, core_tx_ready}, 64'd0);
    chk("t2_head", flit_out, 64'h0000_0000_0001_0050);
    tick();
    chk("t2_held", flit_out, 64'h0000_0000_0001_0050);
    chk("t2_still_full", {63'd0, core_tx_ready}, 64'd0);
    flit_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t2_drain_v", {63'd0, flit_out_valid}, 64'd1);
      chk("t2_drain", flit_out, {8'd0, 48'h100 + 48'(k), 4'h5, 4'(k)});
      if (k == 0) chk("t2_rdy_a", {63'd0, core_tx_ready}, 64'd0);
      if (k == 1) chk("t2_rdy_b", {63'd0, core_tx_ready}, 64'd1);
      tick();
      if (k == 1) core_tx_valid = 1'b0;
    end
    chk("t2_empty", {63'd0, flit_out_valid}, 64'd0);

    // ---- misroute drop and err_clr
    flit_in = 64'h0000_0000_0000_00A3; flit_in_valid = 1'b1;
    tick();
    flit_in_valid = 1'b0; flit_in = 64'hx;
    chk("t3_mis", {63'd0, misroute}, 64'd1);
    chk("t3_ovf", {63'd0, rx_overflow}, 64'd0);
    chk("t3_rxv", {63'd0, core_rx_valid}, 64'd0);
`ifdef NI_STATS_EN
    chk("t3_drop", {48'd0, drop_count}, 64'd1);
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_clr", {63'd0, misroute}, 64'd0);
    // clear and new misroute in the same cycle: flag ends set
    err_clr = 1'b1; flit_in = 64'h0000_0000_0000_0012; flit_in_valid = 1'b1;
    tick();
    err_clr = 1'b0; flit_in_valid = 1'b0; flit_in = 64'hx;
    chk("t3_clr_vs_set", {63'd0, misroute}, 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // ---- RX overflow, then pop frees a slot for a simultaneous arrival
    core_rx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      flit_in = {56'h200 + 56'(k), 4'h7, 4'h5}; flit_in_valid = 1'b1;
      tick();
    end
    flit_in_valid = 1'b0; flit_in = 64'hx;
    chk("t4_ovf", {63'd0, rx_overflow}, 64'd1);
    chk("t4_mis", {63'd0, misroute}, 64'd0);
    chk("t4_rxv", {63'd0, core_rx_valid}, 64'd1);
    chk("t4_src", {60'd0, core_rx_src}, 64'h7);
    chk("t4_data", {8'd0, core_rx_data}, 64'h200);
`ifdef NI_STATS_EN
    chk("t4_drop", {48'd0, drop_count}, 64'd3);
`endif
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_clr", {63'd0, rx_overflow}, 64'd0);
    core_rx_ready = 1'b1;
    flit_in = {56'h2AA, 4'h7, 4'h5}; flit_in_valid = 1'b1;
    tick();
    flit_in_valid = 1'b0; flit_in = 64'hx;
    chk("t4_nopovf", {63'd0, rx_overflow}, 64'd0);
    chk("t4_pop0", {8'd0, core_rx_data}, 64'h201);
    tick();
    chk("t4_pop1", {8'd0, core_rx_data}, 64'h202);
    tick();
    chk("t4_pop2", {8'd0, core_rx_data}, 64'h203);
    tick();
    chk("t4_pop3", {8'd0, core_rx_data}, 64'h2AA);
    tick();
    chk("t4_empty", {63'd0, core_rx_valid}, 64'd0);
`ifdef NI_STATS_EN
    chk("t4_ej", {48'd0, ej_count}, 64'd5);
`endif

    // ---- reset, then 20 flits each direction back-to-back
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    flit_out_ready = 1'b1; core_rx_ready = 1'b1;
    for (int k = 0; k < 21; k++) begin
      if (k < 20) begin
        core_tx_valid = 1'b1; core_tx_dest = 4'(k); core_tx_data = 56'h300 + 56'(k);
        flit_in = {56'h400 + 56'(k), 4'h2, 4'h5}; flit_in_valid = 1'b1;
        chk("t5_txrdy", {63'd0, core_tx_ready}, 64'd1);
      end else begin
        core_tx_valid = 1'b0; flit_in_valid = 1'b0; flit_in = 64'hx;
      end
      if (k > 0) begin
        chk("t5_fo", flit_out, {8'd0, 48'h300 + 48'(k - 1), 4'h5, 4'(k - 1)});
        chk("t5_rx", {8'd0, core_rx_data}, 64'h400 + 64'(k - 1));
      end
      tick();
    end
    chk("t5_fov", {63'd0, flit_out_valid}, 64'd0);
    chk("t5_rxv", {63'd0, core_rx_valid}, 64'd0);
    chk("t5_ovf", {63'd0, rx_overflow}, 64'd0);
    chk("t5_mis", {63'd0, misroute}, 64'd0);
`ifdef NI_STATS_EN
    chk("t5_inj", {48'd0, inj_count}, 64'd20);
    chk("t5_ej", {48'd0, ej_count}, 64'd20);
    chk("t5_drop", {48'd0, drop_count}, 64'd0);
`endif

    // ---- asynchronous reset with both FIFOs half full
    flit_out_ready = 1'b0; core_rx_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      core_tx_valid = 1'b1; core_tx_dest = 4'h3; core_tx_data = 56'h500 + 56'(k);
      flit_in = {56'h600 + 56'(k), 4'h1, 4'h5}; flit_in_valid = 1'b1;
      tick();
    end
    core_tx_valid = 1'b0; flit_in_valid = 1'b0; flit_in = 64'hx;
    chk("t6_pre_fov", {63'd0, flit_out_valid}, 64'd1);
    chk("t6_pre_rxv", {63'd0, core_rx_valid}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_all_zero("t6_async");
    tick();
    rst = 1'b0;
    tick();
    chk("t6_fov", {63'd0, flit_out_valid}, 64'd0);
    chk("t6_txrdy", {63'd0, core_tx_ready}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
